// File: rtl/image_buffer_if.sv
// Bus bundle for image_buffer: write port, random-read request, scan control
// and the registered pixel output stage.
interface image_buffer_if #(
   parameter int pixel_width = 8,
   parameter int coord_width = 4
) ();

   // Handshakes: a read is taken on an edge with rd_req && rd_ready; an output
   // pixel is consumed on an edge with pixel_out_valid && pixel_out_ready, and
   // the pixel plus its flags stay stable while valid is high and ready is low.
   logic                   wr_en;
   logic [coord_width-1:0] wr_x;
   logic [coord_width-1:0] wr_y;
   logic [pixel_width-1:0] wr_data;

   logic                   rd_req;
   logic [coord_width-1:0] rd_x;
   logic [coord_width-1:0] rd_y;
   logic                   rd_ready;

   logic                   scan_start;
   logic                   scan_busy;
   logic                   scan_done;

   logic [pixel_width-1:0] pixel_out;
   logic                   pixel_out_valid;
   logic                   pixel_out_ready;
   logic                   pixel_out_oob;
   logic                   pixel_out_last;

   modport master (
      output wr_en, wr_x, wr_y, wr_data,
      output rd_req, rd_x, rd_y,
      input  rd_ready,
      output scan_start,
      input  scan_busy, scan_done,
      input  pixel_out, pixel_out_valid, pixel_out_oob, pixel_out_last,
      output pixel_out_ready
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_data,
      input  rd_req, rd_x, rd_y,
      output rd_ready,
      input  scan_start,
      output scan_busy, scan_done,
      output pixel_out, pixel_out_valid, pixel_out_oob, pixel_out_last,
      input  pixel_out_ready
   );

endinterface

// File: rtl/image_buffer.sv
// Writable img_width x img_height pixel store with random reads and raster-scan streaming.
// Define IMAGE_BUFFER_INIT_EN to preload entry i with (i*17) truncated to pixel_width.
module image_buffer #(
   parameter int img_width   = 4,
   parameter int img_height  = 4,
   parameter int pixel_width = 8,
   parameter int coord_width = 4
) (
   input  logic       clk,
   input  logic       reset,
   image_buffer_if.slave bus,
   output logic [1:0] dbg_state
);

   localparam int DEPTH = img_width * img_height;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MEM_W = DEPTH * pixel_width;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

`ifdef IMAGE_BUFFER_INIT_EN
   function automatic logic [MEM_W-1:0] init_image();
      logic [MEM_W-1:0] img;
      img = '0;
      for (int i = 0; i < DEPTH; i++) begin
         img[i*pixel_width +: pixel_width] = pixel_width'(i * 17);
      end
      return img;
   endfunction

   logic [MEM_W-1:0] mem_q = init_image();
`else
   logic [MEM_W-1:0] mem_q;
`endif
   logic [MEM_W-1:0] mem_d;

   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   valid_q, valid_d;
   logic [pixel_width-1:0] data_q, data_d;
   logic                   oob_q, oob_d;
   logic                   last_q, last_d;

   logic                   free;
   logic                   rd_ready;
   logic                   wr_in, rd_in;
   logic [31:0]            wr_addr, rd_addr;
   logic [pixel_width-1:0] rd_word, scan_word;
   logic [CNT_W-1:0]       scan_idx;
   logic                   scan_load, scan_last, rd_load;

   always_comb begin
      free     = !valid_q || bus.pixel_out_ready;
      rd_ready = free && (state_q == ST_IDLE);

      wr_in   = (32'(bus.wr_x) < 32'(img_width)) && (32'(bus.wr_y) < 32'(img_height));
      rd_in   = (32'(bus.rd_x) < 32'(img_width)) && (32'(bus.rd_y) < 32'(img_height));
      wr_addr = 32'(bus.wr_y) * 32'(img_width) + 32'(bus.wr_x);
      rd_addr = 32'(bus.rd_y) * 32'(img_width) + 32'(bus.rd_x);

      // The first scan pixel loads on the scan_start edge itself, so the stream
      // starts the cycle after the pulse just like a random read.
      scan_idx  = (state_q == ST_SCAN) ? cnt_q : '0;
      scan_last = (scan_idx == CNT_W'(DEPTH - 1));
      scan_load = free && ((state_q == ST_SCAN) ||
                           ((state_q == ST_IDLE) && bus.scan_start));
      rd_load   = rd_ready && bus.rd_req && !bus.scan_start;
   end

   // Reads see mem_q while writes land in mem_d, giving read-first collisions.
   always_comb begin
      rd_word   = '0;
      scan_word = '0;
      mem_d     = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == 32'(i)) begin
            rd_word = mem_q[i*pixel_width +: pixel_width];
         end
         if (scan_idx == CNT_W'(i)) begin
            scan_word = mem_q[i*pixel_width +: pixel_width];
         end
         if (bus.wr_en && wr_in && (wr_addr == 32'(i))) begin
            mem_d[i*pixel_width +: pixel_width] = bus.wr_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      oob_d   = oob_q;
      last_d  = last_q;

      if (valid_q && bus.pixel_out_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.scan_start) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else if (rd_load) begin
               valid_d = 1'b1;
               data_d  = rd_in ? rd_word : '0;
               oob_d   = !rd_in;
               last_d  = 1'b0;
            end
         end
         ST_SCAN: begin
         end
         ST_DRAIN: begin
            if (valid_q && bus.pixel_out_ready) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (scan_load) begin
         valid_d = 1'b1;
         data_d  = scan_word;
         oob_d   = 1'b0;
         last_d  = scan_last;
         if (scan_last) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_SCAN;
            cnt_d   = scan_idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         oob_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         oob_q   <= oob_d;
         last_q  <= last_d;
      end
   end

   assign bus.rd_ready        = rd_ready;
   assign bus.scan_busy       = busy_q;
   assign bus.scan_done       = done_q;
   assign bus.pixel_out       = data_q;
   assign bus.pixel_out_valid = valid_q;
   assign bus.pixel_out_oob   = oob_q;
   assign bus.pixel_out_last  = last_q;
   assign dbg_state           = state_q;

endmodule

// File: tb/tb_image_buffer.sv
// Directed bench for image_buffer (4x4, 8-bit): reads, writes, out-of-range,
// collisions, full scans with and without backpressure, and reset mid-scan.
module tb_image_buffer;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;
   localparam int CW = 4;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   logic [PW-1:0] exp_mem [W*H];
   logic [PW-1:0] exp_q [$];

   image_buffer_if #(.pixel_width(PW), .coord_width(CW)) bus ();

   image_buffer #(
      .img_width(W), .img_height(H), .pixel_width(PW), .coord_width(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_write(input int x, input int y, input logic [PW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_x    = CW'(x);
      bus.wr_y    = CW'(y);
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
      if (x < W && y < H) exp_mem[y*W + x] = d;
   endtask

   task automatic drive_read(input int x, input int y);
      bus.rd_req = 1'b1;
      bus.rd_x   = CW'(x);
      bus.rd_y   = CW'(y);
      tick();
      bus.rd_req = 1'b0;
   endtask

   task automatic fill_plus_one();
      for (int i = 0; i < W*H; i++) drive_write(i % W, i / W, PW'(i + 1));
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({bus.pixel_out, bus.pixel_out_valid, bus.pixel_out_oob, bus.pixel_out_last,
           bus.scan_busy, bus.scan_done} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got out=%h v=%b oob=%b last=%b busy=%b done=%b, want all 0",
                  bus.pixel_out, bus.pixel_out_valid, bus.pixel_out_oob, bus.pixel_out_last,
                  bus.scan_busy, bus.scan_done);
      end
      vectors++;
      if (dbg_state !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if (bus.rd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_rd_ready: got %b want 1", bus.rd_ready);
      end
   endtask

`ifdef IMAGE_BUFFER_INIT_EN
   task automatic test_init();
      drive_read(3, 3);
      vectors++;
      if (bus.pixel_out !== 8'd255 || bus.pixel_out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL init_3_3: got %h v=%b want ff v=1", bus.pixel_out, bus.pixel_out_valid);
      end
      drive_read(1, 0);
      vectors++;
      if (bus.pixel_out !== 8'd17) begin
         miscompares++;
         $display("FAIL init_1_0: got %h want 11", bus.pixel_out);
      end
      tick();
   endtask
`endif

   task automatic test_read_write();
      fill_plus_one();
      drive_write(2, 1, 8'hA5);
      drive_read(2, 1);
      vectors++;
      if (bus.pixel_out !== 8'hA5 || bus.pixel_out_valid !== 1'b1 ||
          bus.pixel_out_oob !== 1'b0 || bus.pixel_out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL read_2_1: got %h v=%b oob=%b last=%b want a5 v=1 oob=0 last=0",
                  bus.pixel_out, bus.pixel_out_valid, bus.pixel_out_oob, bus.pixel_out_last);
      end
      tick();
      vectors++;
      if (bus.pixel_out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL read_valid_drop: got %b want 0", bus.pixel_out_valid);
      end
   endtask

   task automatic test_oob();
      drive_read(4, 0);
      vectors++;
      if (bus.pixel_out !== 8'h00 || bus.pixel_out_oob !== 1'b1 || bus.pixel_out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL oob_read_4_0: got %h oob=%b v=%b want 00 oob=1 v=1",
                  bus.pixel_out, bus.pixel_out_oob, bus.pixel_out_valid);
      end
      drive_read(0, 4);
      vectors++;
      if (bus.pixel_out !== 8'h00 || bus.pixel_out_oob !== 1'b1) begin
         miscompares++;
         $display("FAIL oob_read_0_4: got %h oob=%b want 00 oob=1", bus.pixel_out, bus.pixel_out_oob);
      end
      drive_write(0, 5, 8'hFF);
      drive_write(7, 0, 8'hFF);
      // back-to-back readback of every entry, rd_req held high across the sweep
      for (int i = 0; i < W*H; i++) begin
         bus.rd_req = 1'b1;
         bus.rd_x   = CW'(i % W);
         bus.rd_y   = CW'(i / W);
         tick();
         vectors++;
         if (bus.pixel_out !== exp_mem[i] || bus.pixel_out_oob !== 1'b0 || bus.pixel_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL readback[%0d]: got %h oob=%b v=%b want %h oob=0 v=1",
                     i, bus.pixel_out, bus.pixel_out_oob, bus.pixel_out_valid, exp_mem[i]);
         end
      end
      bus.rd_req = 1'b0;
      tick();
   endtask

   task automatic test_hold();
      drive_read(3, 0);
      bus.pixel_out_ready = 1'b0;
      bus.rd_req = 1'b1;
      bus.rd_x   = CW'(0);
      bus.rd_y   = CW'(0);
      #1;
      vectors++;
      if (bus.rd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_rd_ready: got %b want 0", bus.rd_ready);
      end
      tick();
      vectors++;
      if (bus.pixel_out !== exp_mem[3] || bus.pixel_out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_data: got %h v=%b want %h v=1", bus.pixel_out, bus.pixel_out_valid, exp_mem[3]);
      end
      bus.pixel_out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.rd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL release_rd_ready: got %b want 1", bus.rd_ready);
      end
      tick();
      bus.rd_req = 1'b0;
      vectors++;
      if (bus.pixel_out !== exp_mem[0]) begin
         miscompares++;
         $display("FAIL release_data: got %h want %h", bus.pixel_out, exp_mem[0]);
      end
      tick();
   endtask

   task automatic test_collision();
      bus.wr_en   = 1'b1;
      bus.wr_x    = CW'(1);
      bus.wr_y    = CW'(1);
      bus.wr_data = 8'h3C;
      drive_read(1, 1);
      bus.wr_en = 1'b0;
      vectors++;
      if (bus.pixel_out !== exp_mem[5]) begin
         miscompares++;
         $display("FAIL collision_old: got %h want %h", bus.pixel_out, exp_mem[5]);
      end
      exp_mem[5] = 8'h3C;
      drive_read(1, 1);
      vectors++;
      if (bus.pixel_out !== 8'h3C) begin
         miscompares++;
         $display("FAIL collision_new: got %h want 3c", bus.pixel_out);
      end
      tick();
   endtask

   task automatic test_scan_full();
      fill_plus_one();
      bus.pixel_out_ready = 1'b1;
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      for (int k = 0; k < W*H; k++) begin
         vectors++;
         if (bus.pixel_out !== PW'(k + 1) || bus.pixel_out_valid !== 1'b1 ||
             bus.pixel_out_last !== (k == W*H-1) || bus.pixel_out_oob !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_pixel[%0d]: got %h v=%b last=%b oob=%b want %h v=1 last=%b oob=0",
                     k, bus.pixel_out, bus.pixel_out_valid, bus.pixel_out_last, bus.pixel_out_oob,
                     PW'(k + 1), (k == W*H-1));
         end
         vectors++;
         if (bus.scan_busy !== 1'b1 || bus.scan_done !== 1'b0 || bus.rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_flags[%0d]: got busy=%b done=%b rd_ready=%b want 1 0 0",
                     k, bus.scan_busy, bus.scan_done, bus.rd_ready);
         end
         tick();
      end
      vectors++;
      if (bus.scan_done !== 1'b1 || bus.scan_busy !== 1'b0 || bus.pixel_out_valid !== 1'b0 || dbg_state !== 2'd0) begin
         miscompares++;
         $display("FAIL scan_done: got done=%b busy=%b v=%b st=%0d want 1 0 0 0",
                  bus.scan_done, bus.scan_busy, bus.pixel_out_valid, dbg_state);
      end
      tick();
      vectors++;
      if (bus.scan_done !== 1'b0) begin
         miscompares++;
         $display("FAIL scan_done_pulse: got %b want 0", bus.scan_done);
      end
   endtask

   task automatic test_scan_backpressure();
      logic [PW-1:0] held;
      logic          was_held;
      logic          done_seen;
      int            cyc;
      exp_q.delete();
      for (int i = 0; i < W*H; i++) exp_q.push_back(PW'(i + 1));
      bus.pixel_out_ready = 1'b1;
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      done_seen = 1'b0;
      cyc = 0;
      while (!done_seen && cyc < 200) begin
         bus.pixel_out_ready = (cyc % 2 == 0);
         #1;
         if (bus.scan_busy) begin
            vectors++;
            if (bus.rd_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL bp_rd_ready[%0d]: got %b want 0", cyc, bus.rd_ready);
            end
         end
         was_held = 1'b0;
         held = bus.pixel_out;
         if (bus.pixel_out_valid && bus.pixel_out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL bp_extra: got %h want no more pixels", bus.pixel_out);
            end else begin
               if (bus.pixel_out !== exp_q[0] || bus.pixel_out_last !== (exp_q.size() == 1)) begin
                  miscompares++;
                  $display("FAIL bp_pixel: got %h last=%b want %h last=%b",
                           bus.pixel_out, bus.pixel_out_last, exp_q[0], (exp_q.size() == 1));
               end
               void'(exp_q.pop_front());
            end
         end else if (bus.pixel_out_valid) begin
            was_held = 1'b1;
         end
         tick();
         if (was_held) begin
            vectors++;
            if (bus.pixel_out !== held || bus.pixel_out_valid !== 1'b1) begin
               miscompares++;
               $display("FAIL bp_hold: got %h v=%b want %h v=1", bus.pixel_out, bus.pixel_out_valid, held);
            end
         end
         if (bus.scan_done === 1'b1) done_seen = 1'b1;
         cyc++;
      end
      vectors++;
      if (!done_seen || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL bp_complete: got done=%b remaining=%0d want done=1 remaining=0",
                  done_seen, exp_q.size());
      end
      bus.pixel_out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_scan();
      bus.pixel_out_ready = 1'b1;
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      repeat (4) tick();
      vectors++;
      if (bus.pixel_out !== 8'd5) begin
         miscompares++;
         $display("FAIL mid_scan_5th: got %h want 05", bus.pixel_out);
      end
      reset = 1'b0;
      tick();
      vectors++;
      if ({bus.pixel_out, bus.pixel_out_valid, bus.pixel_out_oob, bus.pixel_out_last,
           bus.scan_busy, bus.scan_done} !== 13'd0 || dbg_state !== 2'd0) begin
         miscompares++;
         $display("FAIL mid_scan_reset: got out=%h v=%b busy=%b done=%b st=%0d want all 0",
                  bus.pixel_out, bus.pixel_out_valid, bus.scan_busy, bus.scan_done, dbg_state);
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (bus.scan_done !== 1'b0 || bus.pixel_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet[%0d]: got done=%b v=%b want 0 0", k, bus.scan_done, bus.pixel_out_valid);
         end
      end
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      vectors++;
      if (bus.pixel_out !== 8'd1 || bus.pixel_out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_first: got %h v=%b want 01 v=1", bus.pixel_out, bus.pixel_out_valid);
      end
      repeat (W*H - 1) tick();
      vectors++;
      if (bus.pixel_out !== PW'(W*H) || bus.pixel_out_last !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_last: got %h last=%b want 10 last=1", bus.pixel_out, bus.pixel_out_last);
      end
      tick();
      vectors++;
      if (bus.scan_done !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_done: got %b want 1", bus.scan_done);
      end
      tick();
   endtask

   initial begin
      reset               = 1'b0;
      bus.wr_en           = 1'b0;
      bus.wr_x            = '0;
      bus.wr_y            = '0;
      bus.wr_data         = '0;
      bus.rd_req          = 1'b0;
      bus.rd_x            = '0;
      bus.rd_y            = '0;
      bus.scan_start      = 1'b0;
      bus.pixel_out_ready = 1'b1;
      for (int i = 0; i < W*H; i++) exp_mem[i] = '0;

      test_reset();
`ifdef IMAGE_BUFFER_INIT_EN
      test_init();
`endif
      test_read_write();
      test_oob();
      test_hold();
      test_collision();
      test_scan_full();
      test_scan_backpressure();
      test_reset_mid_scan();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
